// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit frames MSB- or LSB-first
// and holds each word in a one-deep valid/ready buffer with sticky overrun.
module shift_deser_rx #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       sin,
    input  logic                       sin_en,
    input  logic                       LR,
    input  logic                       ready,
    input  logic                       clr_ovr,
    output logic [WIDTH-1:0]           Dout,
    output logic                       valid,
    output logic                       overrun,
    output logic                       busy,
    output logic [$clog2(WIDTH)-1:0]   bitcnt
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic             r_lr;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_ovr;

    logic             w_shift;
    logic             w_last;
    logic             w_accept;
    logic             w_drop;
    logic             w_drain;
    logic [WIDTH-1:0] w_word;

    // start always wins, so a bit only shifts in on a non-start SHIFT cycle
    assign w_shift  = (r_state == S_SHIFT) && !start && sin_en;
    assign w_last   = w_shift && (r_bitcnt == CW'(WIDTH - 1));
    assign w_word   = r_lr ? {r_shreg[WIDTH-2:0], sin}
                           : {sin, r_shreg[WIDTH-1:1]};
    assign w_accept = w_last && (!r_valid || ready);
    assign w_drop   = w_last && r_valid && !ready;
    assign w_drain  = !w_last && r_valid && ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (start) begin
                    w_state_nxt = S_SHIFT;
                end else if (w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_lr     <= 1'b0;
        end else if (start) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_lr     <= LR;
        end else if (w_shift) begin
            r_shreg  <= w_word;
            r_bitcnt <= w_last ? '0 : r_bitcnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_dout  <= w_word;
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    // a drop on the same edge as clr_ovr must leave the flag set
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovr <= 1'b0;
        end else if (w_drop) begin
            r_ovr <= 1'b1;
        end else if (clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign Dout    = r_dout;
    assign valid   = r_valid;
    assign overrun = r_ovr;
    assign busy    = (r_state == S_SHIFT);
    assign bitcnt  = r_bitcnt;

endmodule

// File: tb/tb_shift_deser_rx.sv
// Bench for shift_deser_rx: directed scenarios plus random traffic, all
// outputs compared every cycle against a frame-level reference model.
module tb_shift_deser_rx;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          sin;
    logic          sin_en;
    logic          LR;
    logic          ready;
    logic          clr_ovr;
    logic [W-1:0]  Dout;
    logic          valid;
    logic          overrun;
    logic          busy;
    logic [CW-1:0] bitcnt;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit       m_active;
    bit       m_lr;
    bit       m_bits[$];
    bit [W-1:0] m_dout;
    bit       m_valid;
    bit       m_ovr;

    shift_deser_rx #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .sin     (sin),
        .sin_en  (sin_en),
        .LR      (LR),
        .ready   (ready),
        .clr_ovr (clr_ovr),
        .Dout    (Dout),
        .valid   (valid),
        .overrun (overrun),
        .busy    (busy),
        .bitcnt  (bitcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit [W-1:0] assemble(input bit lr);
        bit [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (lr) begin
                w = w | (W'(m_bits[i]) << (W - 1 - i));
            end else begin
                w = w | (W'(m_bits[i]) << i);
            end
        end
        return w;
    endfunction

    // advance the model with the current inputs, clock, then compare
    task automatic tick();
        bit         done;
        bit [W-1:0] word;
        done = 1'b0;
        word = '0;
        if (!reset) begin
            m_active = 1'b0;
            m_lr     = 1'b0;
            m_bits.delete();
            m_dout   = '0;
            m_valid  = 1'b0;
            m_ovr    = 1'b0;
        end else begin
            if (start) begin
                m_active = 1'b1;
                m_lr     = LR;
                m_bits.delete();
            end else if (m_active && sin_en) begin
                m_bits.push_back(sin);
                if (m_bits.size() == W) begin
                    done     = 1'b1;
                    word     = assemble(m_lr);
                    m_active = 1'b0;
                    m_bits.delete();
                end
            end
            if (clr_ovr) m_ovr = 1'b0;
            if (done) begin
                if (!m_valid || ready) begin
                    m_dout  = word;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("dout",    32'(Dout),    32'(m_dout));
        chk("valid",   32'(valid),   32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy",    32'(busy),    32'(m_active));
        chk("bitcnt",  32'(bitcnt),  32'(m_bits.size()));
    endtask

    // start cycle, then W bits; optional gap before bit gap_at,
    // optional LR flipping, ready raised only on the final bit
    task automatic frame(input bit [W-1:0] w, input bit lr,
                         input int gap_at, input int gap_len,
                         input bit flip_lr, input bit rdy_last);
        start  = 1'b1;
        LR     = lr;
        sin_en = 1'($urandom);
        sin    = 1'($urandom);
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    sin_en = 1'b0;
                    sin    = 1'($urandom);
                    tick();
                end
            end
            if (flip_lr) LR = ~LR;
            sin_en = 1'b1;
            sin    = lr ? w[W-1-i] : w[i];
            if (i == W - 1 && rdy_last) ready = 1'b1;
            tick();
        end
        sin_en = 1'b0;
        ready  = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        sin     = 1'b0;
        sin_en  = 1'b0;
        LR      = 1'b0;
        ready   = 1'b0;
        clr_ovr = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid), 32'd0);
        reset = 1'b1;
        tick();

        // MSB-first A5
        frame(8'hA5, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("msb_a5",    32'(Dout),  32'hA5);
        chk("msb_valid", 32'(valid), 32'd1);
        chk("msb_busy",  32'(busy),  32'd0);
        drain();

        // LSB-first with gap, then with LR toggling
        frame(8'hA5, 1'b0, 4, 2, 1'b0, 1'b0);
        chk("lsb_a5", 32'(Dout), 32'hA5);
        drain();
        frame(8'hA5, 1'b0, 4, 2, 1'b1, 1'b0);
        chk("lsb_flip_a5", 32'(Dout), 32'hA5);
        drain();

        // handshake and overrun
        frame(8'h3C, 1'b1, -1, 0, 1'b0, 1'b0);
        frame(8'hC3, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("ovr_keep", 32'(Dout),    32'h3C);
        chk("ovr_set",  32'(overrun), 32'd1);
        frame(8'h77, 1'b0, -1, 0, 1'b0, 1'b1);
        chk("ovr_77",   32'(Dout),  32'h77);
        chk("ovr_77_v", 32'(valid), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        drain();

        // abort after 4 bits, then a full 81 frame
        start = 1'b1;
        LR    = 1'b1;
        tick();
        start  = 1'b0;
        sin_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sin = 1'($urandom);
            tick();
        end
        chk("abort_nov", 32'(valid), 32'd0);
        frame(8'h81, 1'b1, -1, 0, 1'b0, 1'b0);
        chk("abort_81", 32'(Dout), 32'h81);
        drain();

        // start on the completing edge
        start = 1'b1;
        LR    = 1'b0;
        tick();
        start  = 1'b0;
        sin_en = 1'b1;
        for (int i = 0; i < W - 1; i++) begin
            sin = 1'($urandom);
            tick();
        end
        start = 1'b1;
        tick();
        start  = 1'b0;
        sin_en = 1'b0;
        chk("sc_nov",  32'(valid),  32'd0);
        chk("sc_cnt",  32'(bitcnt), 32'd0);
        chk("sc_busy", 32'(busy),   32'd1);

        // reset mid-frame with a word pending
        frame(8'h5A, 1'b1, -1, 0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start  = 1'b0;
        sin_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sin = 1'($urandom);
            tick();
        end
        chk("mid_cnt", 32'(bitcnt), 32'd5);
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        sin_en = 1'b0;
        chk("mid_rst_v", 32'(valid), 32'd0);
        chk("mid_rst_d", 32'(Dout),  32'd0);
        chk("mid_rst_b", 32'(busy),  32'd0);
        frame(8'hE1, 1'b0, 2, 3, 1'b0, 1'b0);
        chk("post_rst", 32'(Dout), 32'hE1);
        drain();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(199) != 0);
            start   = ($urandom_range(15) == 0);
            sin     = 1'($urandom);
            sin_en  = ($urandom_range(9) < 7);
            LR      = 1'($urandom);
            ready   = 1'($urandom);
            clr_ovr = ($urandom_range(29) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_deser_rx.md
Name: shift_deser_rx

Overview:
Serial-to-parallel receiver. It is the receiving end of the serial bit stream produced by the team's multifunction shift register when that register is used as a parallel-load serializer. The block collects WIDTH bits into a shift register, either MSB-first or LSB-first. It then presents the assembled word through a one-deep output buffer with a valid/ready handshake and a sticky overrun flag. It sits between the serial link and the byte-wide datapath.

Parameters:
WIDTH, 8, word width in bits; bit counter is $clog2(WIDTH) bits wide.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low; reset=0 at a posedge resets the block
start  input  1  frame-begin strobe; opens a new frame
sin  input  1  serial data bit
sin_en  input  1  sin is valid this cycle
LR  input  1  bit order, sampled on start: 1 = MSB-first (shift left), 0 = LSB-first (shift right)
ready  input  1  downstream accepts Dout this cycle
clr_ovr  input  1  clears overrun
Dout  output  WIDTH  assembled word, registered
valid  output  1  Dout holds an unconsumed word
overrun  output  1  sticky: a completed word was dropped
busy  output  1  frame in progress (state SHIFT)
bitcnt  output  $clog2(WIDTH)  bits received in the current frame

Behaviour:
- All state updates on posedge clk. Reset is synchronous active-low and has priority over all other inputs, including mid-frame.
- Reset values: Dout=0, valid=0, overrun=0, busy=0, bitcnt=0, internal shreg=0, lr_q=0, state=IDLE.
- States: IDLE, SHIFT.
- IDLE behaviour:
  - start=1 -> SHIFT, bitcnt=0, shreg=0, lr_q<=LR.
  - sin_en is ignored in IDLE and on the start cycle. The start cycle never captures a bit.
- SHIFT, start=1: aborts the current frame. The partial word is discarded and nothing is output. Restart as from IDLE (bitcnt=0, shreg=0, lr_q<=LR). start has priority over a completing bit on the same cycle.
- SHIFT, start=0, sin_en=1:
  - lr_q=1: shreg <= {shreg[WIDTH-2:0], sin}.
  - lr_q=0: shreg <= {sin, shreg[WIDTH-1:1]}.
  - bitcnt increments.
- SHIFT, start=0, sin_en=0: hold all frame state.
- Completion: the edge where bitcnt==WIDTH-1 and sin_en=1 (start=0).
  - The assembled word (shreg including the current bit) is offered to the output buffer.
  - state -> IDLE, bitcnt -> 0.
  - Dout/valid are updated on that same edge, so they are visible the cycle after the last bit.
- Output buffer on completion:
  - If valid=0, or valid=1 and ready=1: Dout <= new word, valid <= 1.
  - Else (valid=1, ready=0): new word is dropped, Dout unchanged, overrun <= 1.
- Output buffer without completion: valid=1 and ready=1 -> valid <= 0, Dout keeps its value.
- Dout is stable whenever valid=1 and ready=0. ready while valid=0 has no effect.
- overrun:
  - Set only by a dropped word.
  - Cleared by clr_ovr=1 or reset.
  - If a drop and clr_ovr occur on the same edge, set wins (overrun=1).
- busy = (state==SHIFT), combinational from the state register. bitcnt reflects the registered counter.
- LR changes during a frame have no effect; only the value sampled at start is used.
- Minimum frame: start cycle plus WIDTH cycles with sin_en=1. Back-to-back frames are supported; start may be asserted the cycle after completion.

Test Plan:
- Reset: drive reset=0 mid-frame (bitcnt=5) with valid=1 -> next cycle all outputs 0 and state IDLE; a subsequent frame completes normally.
- MSB-first: start with LR=1, then sin = 1,0,1,0,0,1,0,1 with sin_en=1 every cycle -> Dout=8'hA5, valid=1 exactly one cycle after the 8th bit; busy low from that cycle.
- LSB-first with gaps: start with LR=0, bits 1,0,1,0,0,1,0,1 with sin_en=0 inserted between bits 3 and 4 for 2 cycles -> Dout=8'hA5. Repeat with LR toggled mid-frame -> result unchanged.
- Handshake and overrun:
  - Receive 8'h3C with ready=0, then a second frame 8'hC3 -> Dout stays 8'h3C, overrun=1.
  - Third frame 8'h77 completing on a cycle with ready=1 -> Dout=8'h77, valid=1.
  - clr_ovr=1 -> overrun=0.
- Abort: start, 4 bits, start again, then 8 bits forming 8'h81 -> single valid word 8'h81, no spurious valid.
- Start on completing edge: assert start on the same cycle as the 8th sin_en -> no word output, bitcnt=0, busy=1.
